// File: rtl/latch_bank_write_arbiter.sv
// latch_bank_write_arbiter: round-robin owner of a shared gated-latch bank,
// sequencing each write as setup, gate, hold with a one-cycle ACK.
module latch_bank_write_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    input  logic [N_REQ-1:0]       REQ,
    input  logic [N_REQ*WIDTH-1:0] WDATA,
    output logic [N_REQ-1:0]       ACK,
    output logic [WIDTH-1:0]       LAT_D,
    output logic                   LAT_EN,
    output logic                   BUSY,
    output logic [GW-1:0]          GNT_ID
);
    typedef enum logic [1:0] {IDLE, SETUP, GATE, HOLD} state_t;
    state_t state_q, state_d;
    logic [GW-1:0] ptr_q, ptr_d, gnt_q, gnt_d, off, win;
    logic [WIDTH-1:0] lat_d_q, lat_d_d;
    logic lat_en_q, lat_en_d, busy_q, busy_d, found, grant;
    logic [N_REQ-1:0] ack_q, ack_d, own, arb_v, rot;
    logic [2*N_REQ-1:0] dbl;
    logic [GW:0] sum;
    always_comb begin
        own = {{(N_REQ-1){1'b0}}, 1'b1} << gnt_q;
        // The owner's REQ is still high while its ACK shows, so hide it in HOLD.
        arb_v = (state_q == HOLD) ? REQ & ~own : REQ;
        dbl = {arb_v, arb_v};
        rot = N_REQ'(dbl >> ({1'b0, ptr_q} + (GW+1)'(1)));
        off = '0;
        for (int i = N_REQ-1; i >= 0; i--) if (rot[i]) off = GW'(i);
        found = |rot;
        sum = {1'b0, ptr_q} + (GW+1)'(1) + {1'b0, off};
        win = (sum >= (GW+1)'(N_REQ)) ? GW'(sum - (GW+1)'(N_REQ)) : GW'(sum);
        grant = found && (state_q == IDLE || state_q == HOLD);
        state_d = (state_q == SETUP) ? GATE : (state_q == GATE) ? HOLD : grant ? SETUP : IDLE;
        ptr_d = grant ? win : ptr_q;
        gnt_d = grant ? win : gnt_q;
        lat_d_d = grant ? WDATA[win*WIDTH +: WIDTH] : lat_d_q;
        lat_en_d = state_d == GATE;
        busy_d = state_d != IDLE;
        ack_d = (state_d == HOLD) ? own : '0;
    end
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q  <= IDLE;
            ptr_q    <= GW'(N_REQ-1);
            gnt_q    <= '0;
            lat_d_q  <= '0;
            lat_en_q <= 1'b0;
            busy_q   <= 1'b0;
            ack_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            lat_d_q  <= lat_d_d;
            lat_en_q <= lat_en_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
        end
    end
    assign ACK    = ack_q;
    assign LAT_D  = lat_d_q;
    assign LAT_EN = lat_en_q;
    assign BUSY   = busy_q;
    assign GNT_ID = gnt_q;
endmodule

// File: tb/tb_latch_bank_write_arbiter.sv
// tb_latch_bank_write_arbiter: directed per-cycle vectors plus fairness and owner-masking sequences.
module tb_latch_bank_write_arbiter;
    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    logic [3:0] REQ = '0;
    logic [31:0] WDATA = '0;
    logic [3:0] ACK;
    logic [7:0] LAT_D;
    logic LAT_EN, BUSY;
    logic [1:0] GNT_ID;
    logic [15:0] obs;
    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    latch_bank_write_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
        .CLK(CLK), .RSTn(RSTn), .REQ(REQ), .WDATA(WDATA),
        .ACK(ACK), .LAT_D(LAT_D), .LAT_EN(LAT_EN), .BUSY(BUSY), .GNT_ID(GNT_ID)
    );

    assign obs = {ACK, LAT_EN, LAT_D, BUSY, GNT_ID};

    typedef struct {
        logic        rstn;
        logic [3:0]  req;
        logic [31:0] wdata;
        logic [15:0] exp;
    } vec_t;
    vec_t vq[$];

    task automatic add(input logic rstn, input logic [3:0] req, input logic [31:0] wd,
                       input logic [3:0] ack, input logic en, input logic [7:0] d,
                       input logic busy, input logic [1:0] gnt);
        vec_t v;
        v.rstn = rstn;
        v.req = req;
        v.wdata = wd;
        v.exp = {ack, en, d, busy, gnt};
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] got[8];
        int n;
        // rstn, req, wdata -> ack, lat_en, lat_d, busy, gnt after the edge
        add(0, 4'b0000, 32'h0,        4'h0, 0, 8'h00, 0, 2'd0);
        add(1, 4'b0001, 32'h000000A5, 4'h0, 0, 8'hA5, 1, 2'd0);
        add(1, 4'b0001, 32'h000000A5, 4'h0, 1, 8'hA5, 1, 2'd0);
        add(1, 4'b0001, 32'h000000A5, 4'h1, 0, 8'hA5, 1, 2'd0);
        add(1, 4'b0000, 32'h000000A5, 4'h0, 0, 8'hA5, 0, 2'd0);
        add(0, 4'b0000, 32'h0,        4'h0, 0, 8'h00, 0, 2'd0);
        add(1, 4'b1111, 32'h44332211, 4'h0, 0, 8'h11, 1, 2'd0);
        add(1, 4'b1111, 32'h44332211, 4'h0, 1, 8'h11, 1, 2'd0);
        add(1, 4'b1111, 32'h44332211, 4'h1, 0, 8'h11, 1, 2'd0);
        add(1, 4'b1111, 32'h44332211, 4'h0, 0, 8'h22, 1, 2'd1);
        add(1, 4'b1110, 32'h44332211, 4'h0, 1, 8'h22, 1, 2'd1);
        add(1, 4'b1110, 32'h44332211, 4'h2, 0, 8'h22, 1, 2'd1);
        add(1, 4'b1110, 32'h44332211, 4'h0, 0, 8'h33, 1, 2'd2);
        add(1, 4'b1100, 32'h44332211, 4'h0, 1, 8'h33, 1, 2'd2);
        add(1, 4'b1100, 32'h44332211, 4'h4, 0, 8'h33, 1, 2'd2);
        add(1, 4'b1100, 32'h44332211, 4'h0, 0, 8'h44, 1, 2'd3);
        add(1, 4'b1000, 32'h44332211, 4'h0, 1, 8'h44, 1, 2'd3);
        add(1, 4'b1000, 32'h44332211, 4'h8, 0, 8'h44, 1, 2'd3);
        add(1, 4'b1000, 32'h44332211, 4'h0, 0, 8'h44, 0, 2'd3);
        add(1, 4'b0000, 32'h44332211, 4'h0, 0, 8'h44, 0, 2'd3);
        add(1, 4'b0100, 32'h003C0000, 4'h0, 0, 8'h3C, 1, 2'd2);
        add(1, 4'b0000, 32'h00FF0000, 4'h0, 1, 8'h3C, 1, 2'd2);
        add(1, 4'b0000, 32'h00FF0000, 4'h4, 0, 8'h3C, 1, 2'd2);
        add(1, 4'b0000, 32'h00FF0000, 4'h0, 0, 8'h3C, 0, 2'd2);
        add(1, 4'b1000, 32'h55000000, 4'h0, 0, 8'h55, 1, 2'd3);
        add(1, 4'b1000, 32'h55000000, 4'h0, 1, 8'h55, 1, 2'd3);
        add(0, 4'b1000, 32'h55000000, 4'h0, 0, 8'h00, 0, 2'd0);
        add(1, 4'b1111, 32'h44332211, 4'h0, 0, 8'h11, 1, 2'd0);
        add(1, 4'b1111, 32'h44332211, 4'h0, 1, 8'h11, 1, 2'd0);
        add(1, 4'b1111, 32'h44332211, 4'h1, 0, 8'h11, 1, 2'd0);
        foreach (vq[i]) begin
            RSTn = vq[i].rstn;
            REQ = vq[i].req;
            WDATA = vq[i].wdata;
            step();
            chk($sformatf("vec%0d", i), {16'h0, obs}, {16'h0, vq[i].exp});
        end

        // REQ[0] and REQ[2] held forever: grants must alternate
        RSTn = 1'b0;
        REQ = '0;
        step();
        RSTn = 1'b1;
        REQ = 4'b0101;
        WDATA = 32'h00BB00AA;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (ACK != 4'h0) begin
                if (n < 8) got[n] = ACK;
                n++;
            end
        end
        chk("fair_count", n, 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("fair_ack%0d", k), {28'h0, got[k]}, (k % 2 == 1) ? 32'h4 : 32'h1);

        // owner keeps REQ high through HOLD: exactly one write, then IDLE
        RSTn = 1'b0;
        REQ = '0;
        step();
        RSTn = 1'b1;
        REQ = 4'b0010;
        WDATA = 32'h00007700;
        step();
        step();
        step();
        chk("mask_ack", {28'h0, ACK}, 32'h2);
        step();
        chk("mask_idle", {31'h0, BUSY}, 32'h0);
        REQ = '0;
        step();
        chk("mask_still_idle", {27'h0, BUSY, ACK}, 32'h0);
        REQ = 4'b0010;
        step();
        chk("mask_regrant", {21'h0, BUSY, LAT_D, GNT_ID}, {21'h0, 1'b1, 8'h77, 2'd1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
